reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard_if.sv | 49 ++++
 rtl/reg_scoreboard.sv | 103 ++++++++++
 tb/tb_reg_scoreboard.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
// Issue/writeback bundle for the register scoreboard.
//
// Handshake: an issue slot transfers when isN_valid and isN_ready are both
// high on a rising clk edge. isN_ready is combinational, may depend on
// isN_valid, and the issuer must not wait for ready before asserting valid.
// Writeback ports have no ready; wbN_en qualifies wbN_addr on every edge.
interface reg_scoreboard_if #(
    parameter int STALL_CNT_W = 16
);
    logic                   flush;
    logic                   is0_valid;
    logic [4:0]             is0_rj;
    logic [4:0]             is0_rk;
    logic [4:0]             is0_rd;
    logic                   is0_rj_use;
    logic                   is0_rk_use;
    logic                   is0_rd_we;
    logic                   is1_valid;
    logic [4:0]             is1_rj;
    logic [4:0]             is1_rk;
    logic [4:0]             is1_rd;
    logic                   is1_rj_use;
    logic                   is1_rk_use;
    logic                   is1_rd_we;
    logic                   is0_ready;
    logic                   is1_ready;
    logic                   wb0_en;
    logic [4:0]             wb0_addr;
    logic                   wb1_en;
    logic [4:0]             wb1_addr;
    logic [31:0]            busy_vec;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output flush,
        output is0_valid, is0_rj, is0_rk, is0_rd, is0_rj_use, is0_rk_use, is0_rd_we,
        output is1_valid, is1_rj, is1_rk, is1_rd, is1_rj_use, is1_rk_use, is1_rd_we,
        output wb0_en, wb0_addr, wb1_en, wb1_addr,
        input  is0_ready, is1_ready, busy_vec, stall_cnt
    );

    modport slave (
        input  flush,
        input  is0_valid, is0_rj, is0_rk, is0_rd, is0_rj_use, is0_rk_use, is0_rd_we,
        input  is1_valid, is1_rj, is1_rk, is1_rd, is1_rj_use, is1_rk_use, is1_rd_we,
        input  wb0_en, wb0_addr, wb1_en, wb1_addr,
        output is0_ready, is1_ready, busy_vec, stall_cnt
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Dual-issue register scoreboard: tracks one pending-write bit per
// architectural register, gates in-order issue of two slots on RAW/WAW
// hazards, and counts slot 0 stall cycles with a saturating counter.
module reg_scoreboard #(
    parameter int STALL_CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    reg_scoreboard_if.slave   sb
);

    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    logic [31:0]            busy_q;
    logic [31:0]            busy_next;
    logic [31:0]            wb_clr;
    logic [31:0]            eff_busy;
    logic [31:0]            set_vec;
    logic [STALL_CNT_W-1:0] stall_q;
    logic                   hz0;
    logic                   hz1;
    logic                   pair_dep;
    logic                   ready0;
    logic                   ready1;
    logic                   fire0;
    logic                   fire1;

    // A slot is blocked if any register it touches still has a write pending.
    function automatic logic slot_hazard(
        input logic [31:0] eb,
        input logic [4:0]  rj,
        input logic [4:0]  rk,
        input logic [4:0]  rd,
        input logic        rj_use,
        input logic        rk_use,
        input logic        rd_we
    );
        return (rj_use & eb[rj]) | (rk_use & eb[rk]) | (rd_we & eb[rd]);
    endfunction

    // Writebacks landing this cycle release their registers immediately.
    always_comb begin
        wb_clr = '0;
        if (sb.wb0_en) wb_clr[sb.wb0_addr] = 1'b1;
        if (sb.wb1_en) wb_clr[sb.wb1_addr] = 1'b1;
        eff_busy = busy_q & ~wb_clr;
    end

    // Hazard detection and in-order ready generation for both slots.
    always_comb begin
        hz0 = slot_hazard(eff_busy, sb.is0_rj, sb.is0_rk, sb.is0_rd,
                          sb.is0_rj_use, sb.is0_rk_use, sb.is0_rd_we);
        hz1 = slot_hazard(eff_busy, sb.is1_rj, sb.is1_rk, sb.is1_rd,
                          sb.is1_rj_use, sb.is1_rk_use, sb.is1_rd_we);
        // Slot 1 may not consume or overwrite what slot 0 produces this cycle.
        pair_dep = sb.is0_rd_we && (sb.is0_rd != 5'd0) &&
                   ((sb.is1_rj_use && (sb.is1_rj == sb.is0_rd)) ||
                    (sb.is1_rk_use && (sb.is1_rk == sb.is0_rd)) ||
                    (sb.is1_rd_we  && (sb.is1_rd == sb.is0_rd)));
        ready0 = sb.is0_valid & ~hz0 & ~sb.flush & ~rst;
        ready1 = sb.is1_valid & sb.is0_valid & ready0 & ~hz1 & ~pair_dep &
                 ~sb.flush & ~rst;
        fire0  = sb.is0_valid & ready0;
        fire1  = sb.is1_valid & ready1;
    end

    // Issued destinations become busy; a set beats a same-cycle clear, r0 never busy.
    always_comb begin
        set_vec = '0;
        if (fire0 && sb.is0_rd_we && (sb.is0_rd != 5'd0)) set_vec[sb.is0_rd] = 1'b1;
        if (fire1 && sb.is1_rd_we && (sb.is1_rd != 5'd0)) set_vec[sb.is1_rd] = 1'b1;
        if (sb.flush) begin
            busy_next = '0;
        end else begin
            busy_next = (busy_q & ~wb_clr) | set_vec;
        end
        busy_next[0] = 1'b0;
    end

    // Busy register; reset outranks flush, writeback and issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    // Saturating count of cycles where slot 0 wanted to issue but was held off.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (sb.is0_valid && !ready0 && !sb.flush && (stall_q != STALL_MAX)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign sb.is0_ready = ready0;
    assign sb.is1_ready = ready1;
    assign sb.busy_vec  = busy_q;
    assign sb.stall_cnt = stall_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios plus random traffic checked
// against a behavioural scoreboard model. A second instance with a 2-bit
// stall counter shares the same stimulus to exercise saturation.
module tb_reg_scoreboard;

    logic clk;
    logic rst;

    reg_scoreboard_if #(.STALL_CNT_W(16)) sb ();
    reg_scoreboard_if #(.STALL_CNT_W(2))  sb_s ();

    reg_scoreboard #(.STALL_CNT_W(16)) dut   (.clk(clk), .rst(rst), .sb(sb));
    reg_scoreboard #(.STALL_CNT_W(2))  dut_s (.clk(clk), .rst(rst), .sb(sb_s));

    assign sb_s.flush      = sb.flush;
    assign sb_s.is0_valid  = sb.is0_valid;
    assign sb_s.is0_rj     = sb.is0_rj;
    assign sb_s.is0_rk     = sb.is0_rk;
    assign sb_s.is0_rd     = sb.is0_rd;
    assign sb_s.is0_rj_use = sb.is0_rj_use;
    assign sb_s.is0_rk_use = sb.is0_rk_use;
    assign sb_s.is0_rd_we  = sb.is0_rd_we;
    assign sb_s.is1_valid  = sb.is1_valid;
    assign sb_s.is1_rj     = sb.is1_rj;
    assign sb_s.is1_rk     = sb.is1_rk;
    assign sb_s.is1_rd     = sb.is1_rd;
    assign sb_s.is1_rj_use = sb.is1_rj_use;
    assign sb_s.is1_rk_use = sb.is1_rk_use;
    assign sb_s.is1_rd_we  = sb.is1_rd_we;
    assign sb_s.wb0_en     = sb.wb0_en;
    assign sb_s.wb0_addr   = sb.wb0_addr;
    assign sb_s.wb1_en     = sb.wb1_en;
    assign sb_s.wb1_addr   = sb.wb1_addr;

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit [31:0] m_busy;
    int        m_stall;
    int        m_stall_s;

    // Values seen in the most recent cycle
    logic        obs_r0;
    logic        obs_r1;
    logic [31:0] obs_busy;
    logic [31:0] obs_stall;
    logic [31:0] obs_stall_s;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit touches_busy(input bit [31:0] eb, input logic [4:0] rj, input logic [4:0] rk,
                                        input logic [4:0] rd, input logic ju, input logic ku,
                                        input logic we);
        bit hit;
        hit = 1'b0;
        if (ju && eb[rj]) hit = 1'b1;
        if (ku && eb[rk]) hit = 1'b1;
        if (we && eb[rd]) hit = 1'b1;
        return hit;
    endfunction

    // Driver tasks
    task automatic clear_inputs();
        sb.flush = 0;
        sb.is0_valid = 0; sb.is0_rj = 0; sb.is0_rk = 0; sb.is0_rd = 0;
        sb.is0_rj_use = 0; sb.is0_rk_use = 0; sb.is0_rd_we = 0;
        sb.is1_valid = 0; sb.is1_rj = 0; sb.is1_rk = 0; sb.is1_rd = 0;
        sb.is1_rj_use = 0; sb.is1_rk_use = 0; sb.is1_rd_we = 0;
        sb.wb0_en = 0; sb.wb0_addr = 0; sb.wb1_en = 0; sb.wb1_addr = 0;
    endtask

    task automatic set_s0(input logic v, input logic [4:0] rj, input logic ju, input logic [4:0] rk,
                          input logic ku, input logic [4:0] rd, input logic we);
        sb.is0_valid = v; sb.is0_rj = rj; sb.is0_rj_use = ju; sb.is0_rk = rk;
        sb.is0_rk_use = ku; sb.is0_rd = rd; sb.is0_rd_we = we;
    endtask

    task automatic set_s1(input logic v, input logic [4:0] rj, input logic ju, input logic [4:0] rk,
                          input logic ku, input logic [4:0] rd, input logic we);
        sb.is1_valid = v; sb.is1_rj = rj; sb.is1_rj_use = ju; sb.is1_rk = rk;
        sb.is1_rk_use = ku; sb.is1_rd = rd; sb.is1_rd_we = we;
    endtask

    // One clock: compare readys before the edge, advance the model, compare state after.
    task automatic cycle();
        bit [31:0] eb;
        bit [31:0] eb1;
        bit        e0;
        bit        e1;
        #1;
        eb = m_busy;
        if (sb.wb0_en) eb[sb.wb0_addr] = 1'b0;
        if (sb.wb1_en) eb[sb.wb1_addr] = 1'b0;
        e0 = !rst && !sb.flush && sb.is0_valid &&
             !touches_busy(eb, sb.is0_rj, sb.is0_rk, sb.is0_rd,
                           sb.is0_rj_use, sb.is0_rk_use, sb.is0_rd_we);
        // Slot 1 sees slot 0's destination as already pending.
        eb1 = eb;
        if (e0 && sb.is0_rd_we && sb.is0_rd != 0) eb1[sb.is0_rd] = 1'b1;
        e1 = !rst && !sb.flush && sb.is1_valid && e0 &&
             !touches_busy(eb1, sb.is1_rj, sb.is1_rk, sb.is1_rd,
                           sb.is1_rj_use, sb.is1_rk_use, sb.is1_rd_we);
        obs_r0 = sb.is0_ready;
        obs_r1 = sb.is1_ready;
        check_eq("is0_ready", 32'(obs_r0), 32'(e0));
        check_eq("is1_ready", 32'(obs_r1), 32'(e1));
        check_eq("is0_ready_w2", 32'(sb_s.is0_ready), 32'(e0));
        if (rst) begin
            m_busy = '0;
            m_stall = 0;
            m_stall_s = 0;
        end else begin
            if (sb.is0_valid && !e0 && !sb.flush) begin
                if (m_stall < 65535) m_stall++;
                if (m_stall_s < 3) m_stall_s++;
            end
            if (sb.flush) begin
                m_busy = '0;
            end else begin
                if (e0 && sb.is0_rd_we && sb.is0_rd != 0) eb[sb.is0_rd] = 1'b1;
                if (e1 && sb.is1_rd_we && sb.is1_rd != 0) eb[sb.is1_rd] = 1'b1;
                m_busy = eb;
            end
        end
        @(posedge clk);
        #1;
        obs_busy    = sb.busy_vec;
        obs_stall   = 32'(sb.stall_cnt);
        obs_stall_s = 32'(sb_s.stall_cnt);
        check_eq("busy_vec", obs_busy, m_busy);
        check_eq("stall_cnt", obs_stall, 32'(m_stall));
        check_eq("stall_cnt_w2", obs_stall_s, 32'(m_stall_s));
        check_eq("busy_vec_w2", sb_s.busy_vec, m_busy);
    endtask

    logic [1:0] sat_tbl [6];

    initial begin
        sat_tbl = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        m_busy = '0; m_stall = 0; m_stall_s = 0;
        clear_inputs();
        rst = 1'b1;
        set_s0(1, 0, 0, 0, 0, 1, 1);
        cycle();
        check_eq("rst_ready", 32'(obs_r0), 32'd0);
        cycle();
        check_eq("rst_busy", obs_busy, 32'd0);
        check_eq("rst_stall", obs_stall, 32'd0);
        rst = 1'b0;
        clear_inputs();
        cycle();

        // Dependent read waits one cycle, then issues on same-cycle writeback.
        set_s0(1, 0, 0, 0, 0, 5, 1);
        cycle();
        check_eq("r5_set", obs_busy, 32'h20);
        set_s0(1, 5, 1, 0, 0, 0, 0);
        cycle();
        check_eq("r5_stall_ready", 32'(obs_r0), 32'd0);
        check_eq("r5_stall_cnt", obs_stall, 32'd1);
        sb.wb0_en = 1; sb.wb0_addr = 5;
        cycle();
        check_eq("r5_bypass_ready", 32'(obs_r0), 32'd1);
        check_eq("r5_cleared", obs_busy, 32'd0);
        clear_inputs();

        // Intra-pair dependency holds slot 1.
        set_s0(1, 0, 0, 0, 0, 7, 1);
        set_s1(1, 0, 0, 7, 1, 0, 0);
        cycle();
        check_eq("pair_r0", 32'(obs_r0), 32'd1);
        check_eq("pair_r1", 32'(obs_r1), 32'd0);
        check_eq("pair_busy", obs_busy, 32'h80);
        clear_inputs();
        sb.wb1_en = 1; sb.wb1_addr = 7;
        cycle();
        clear_inputs();

        // Slot 1 never issues alone or past a stalled slot 0.
        set_s1(1, 1, 1, 2, 1, 12, 1);
        cycle();
        check_eq("s1_alone", 32'(obs_r1), 32'd0);
        set_s0(1, 0, 0, 0, 0, 3, 1);
        set_s1(0, 0, 0, 0, 0, 0, 0);
        cycle();
        set_s0(1, 3, 1, 0, 0, 0, 0);
        set_s1(1, 1, 1, 2, 1, 12, 1);
        cycle();
        check_eq("s1_behind_stall", 32'(obs_r1), 32'd0);
        clear_inputs();
        sb.wb0_en = 1; sb.wb0_addr = 3;
        cycle();
        clear_inputs();

        // Set wins over a same-cycle clear; rd=0 sets nothing.
        set_s0(1, 0, 0, 0, 0, 9, 1);
        cycle();
        sb.wb0_en = 1; sb.wb0_addr = 9;
        cycle();
        check_eq("set_wins", 32'(obs_busy[9]), 32'd1);
        clear_inputs();
        set_s0(1, 0, 0, 0, 0, 0, 1);
        cycle();
        check_eq("rd0_noop", obs_busy, 32'h200);
        clear_inputs();
        sb.wb0_en = 1; sb.wb0_addr = 9; sb.wb1_en = 1; sb.wb1_addr = 9;
        cycle();
        check_eq("dual_wb", obs_busy, 32'd0);
        clear_inputs();

        // Flush drops everything pending.
        set_s0(1, 0, 0, 0, 0, 8, 1);
        set_s1(1, 0, 0, 0, 0, 9, 1);
        cycle();
        set_s0(1, 0, 0, 0, 0, 10, 1);
        set_s1(1, 0, 0, 0, 0, 11, 1);
        cycle();
        check_eq("pre_flush", obs_busy, 32'h0000_0F00);
        clear_inputs();
        sb.flush = 1;
        set_s0(1, 0, 0, 0, 0, 4, 1);
        cycle();
        check_eq("flush_r0", 32'(obs_r0), 32'd0);
        check_eq("flush_busy", obs_busy, 32'd0);
        clear_inputs();

        // Fresh counters, 12 stall cycles, saturation of the narrow copy, then reset.
        rst = 1;
        cycle();
        rst = 0;
        set_s0(1, 0, 0, 0, 0, 3, 1);
        cycle();
        set_s0(1, 0, 0, 3, 1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (i < 6) check_eq("sat_w2", obs_stall_s, 32'(sat_tbl[i]));
        end
        check_eq("stall_12", obs_stall, 32'd12);
        rst = 1;
        cycle();
        check_eq("rst_mid_ready", 32'(obs_r0), 32'd0);
        check_eq("rst_mid_stall", obs_stall, 32'd0);
        check_eq("rst_mid_busy", obs_busy, 32'd0);
        rst = 0;
        clear_inputs();
        sb.wb0_en = 1; sb.wb0_addr = 3;
        cycle();
        clear_inputs();

        // Random traffic over a small register window to provoke hazards.
        for (int n = 0; n < 2000; n++) begin
            rst = ($urandom_range(0, 149) == 0);
            sb.flush = ($urandom_range(0, 29) == 0);
            set_s0($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            set_s1($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            sb.wb0_en = 1'($urandom_range(0, 1));
            sb.wb0_addr = 5'($urandom_range(0, 7));
            sb.wb1_en = 1'($urandom_range(0, 1));
            sb.wb1_addr = 5'($urandom_range(0, 7));
            cycle();
        end
        rst = 0;
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
